// File: rtl/frame_demux_pkg.sv
// Shared types and width helpers for the frame deserialiser.
//   state_t : collector FSM states (ST_COLLECT filling shadow, ST_HOLD shadow full and blocked)
//   idx_w   : width of the field index for n fields
//   gap_w   : width of the inter-word gap counter for a given timeout
//   done_w  : width of the o_done down-counter
package frame_demux_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int gap_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

  function automatic int done_w(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-word gap timer for a partially collected frame.
//   i_clk    : clock
//   reset    : synchronous, active-low
//   i_clr    : a word arrived this cycle; restart the gap count
//   i_en     : a partial frame is pending; count idle cycles
//   o_expire : gap has reached TIMEOUT; the pending frame is discarded on this edge
// TIMEOUT = 0 disables expiry entirely.
module frame_gap_timer
  import frame_demux_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int GAP_W = gap_w(TIMEOUT);

  logic [GAP_W-1:0] count_reg, count_next;

  // The counter restarts whenever the window closes, so it can never pass
  // TIMEOUT and never wraps.
  always_comb begin
    count_next = count_reg;
    if (!i_en || i_clr) begin
      count_next = '0;
    end else if (count_reg == GAP_W'(TIMEOUT)) begin
      count_next = '0;
    end else begin
      count_next = count_reg + GAP_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign o_expire = (TIMEOUT > 0) && i_en && (count_reg == GAP_W'(TIMEOUT));

endmodule

// File: rtl/frame_demux_n.sv
// Parametrised byte-stream frame deserialiser.
// Collects N_FIELDS words into a shadow buffer; a complete frame moves into
// the output register and is handed off with o_valid / i_frame_ready.
//   i_clk         : clock, rising edge
//   reset         : synchronous, active-low
//   i_ready       : word strobe, i_data sampled when high
//   i_data        : incoming word
//   i_frame_ready : downstream accepts the frame held in o_fields
//   o_fields      : completed frame, field k at [k*DATA_W +: DATA_W]
//   o_opcode      : last field of o_fields
//   o_valid       : o_fields holds an unconsumed frame
//   o_done        : high DONE_CYCLES cycles after each output load
//   o_timeout     : one-cycle pulse when a partial frame is discarded
//   o_overflow    : sticky, a word was dropped while blocked in ST_HOLD
//   o_index       : next shadow slot to be written
module frame_demux_n
  import frame_demux_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_FIELDS    = 3,
  parameter int DONE_CYCLES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic                         i_clk,
  input  logic                         reset,
  input  logic                         i_ready,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_frame_ready,
  output logic [N_FIELDS*DATA_W-1:0]   o_fields,
  output logic [DATA_W-1:0]            o_opcode,
  output logic                         o_valid,
  output logic                         o_done,
  output logic                         o_timeout,
  output logic                         o_overflow,
  output logic [idx_w(N_FIELDS)-1:0]   o_index
);

  localparam int IDX_W  = idx_w(N_FIELDS);
  localparam int DONE_W = done_w(DONE_CYCLES);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   index_reg, index_next;
  logic [DATA_W-1:0]  shadow_reg [N_FIELDS];
  logic [DATA_W-1:0]  shadow_next [N_FIELDS];
  logic [DATA_W-1:0]  out_reg [N_FIELDS];
  logic [DATA_W-1:0]  out_next [N_FIELDS];
  logic               valid_reg, valid_next;
  logic [DONE_W-1:0]  done_reg, done_next;
  logic               timeout_reg, timeout_next;
  logic               overflow_reg, overflow_next;

  logic               expire, gap_en, collect, accept, out_free;
  logic               last_slot, complete, load_new, load_hold;
  logic [IDX_W-1:0]   slot;

  assign collect  = (state_reg == ST_COLLECT);
  assign accept   = valid_reg && i_frame_ready;
  assign out_free = !valid_reg || accept;
  assign gap_en   = (TIMEOUT > 0) && collect && (index_reg != '0);

  // An expiring partial frame is discarded before an arriving word is
  // stored, so a word on the expiry edge lands in field 0.
  assign slot      = expire ? '0 : index_reg;
  assign last_slot = (slot == IDX_W'(N_FIELDS - 1));
  assign complete  = collect && i_ready && last_slot;
  assign load_new  = complete && out_free;
  assign load_hold = !collect && accept;

  frame_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_clr    (i_ready),
    .i_en     (gap_en),
    .o_expire (expire)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_reg <= ST_COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COLLECT: if (complete && !out_free) state_next = ST_HOLD;
      ST_HOLD:    if (accept) state_next = ST_COLLECT;
      default:    state_next = ST_COLLECT;
    endcase
  end

  // Datapath next values
  always_comb begin
    shadow_next   = shadow_reg;
    out_next      = out_reg;
    index_next    = index_reg;
    valid_next    = valid_reg;
    done_next     = (done_reg != '0) ? done_reg - DONE_W'(1) : '0;
    timeout_next  = expire;
    overflow_next = overflow_reg || (!collect && i_ready);

    if (accept) valid_next = 1'b0;

    if (collect) begin
      if (expire) index_next = '0;
      if (i_ready) begin
        for (int k = 0; k < N_FIELDS; k++) begin
          if (slot == IDX_W'(k)) shadow_next[k] = i_data;
        end
        // A blocked completion leaves index at the last slot while in ST_HOLD.
        if (!last_slot)    index_next = slot + IDX_W'(1);
        else if (out_free) index_next = '0;
        else               index_next = slot;
      end
    end else if (accept) begin
      index_next = '0;
    end

    // The last word bypasses the shadow so the frame is visible next cycle.
    if (load_new) begin
      for (int k = 0; k < N_FIELDS; k++) begin
        out_next[k] = (k == N_FIELDS - 1) ? i_data : shadow_reg[k];
      end
    end
    if (load_hold) out_next = shadow_reg;

    // A restart while o_done is active reloads the full count.
    if (load_new || load_hold) begin
      valid_next = 1'b1;
      done_next  = DONE_W'(DONE_CYCLES);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      for (int k = 0; k < N_FIELDS; k++) begin
        shadow_reg[k] <= '0;
        out_reg[k]    <= '0;
      end
      index_reg    <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= '0;
      timeout_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      shadow_reg   <= shadow_next;
      out_reg      <= out_next;
      index_reg    <= index_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
      overflow_reg <= overflow_next;
    end
  end

  // Outputs
  genvar gi;
  generate
    for (gi = 0; gi < N_FIELDS; gi++) begin : g_fields
      assign o_fields[gi*DATA_W +: DATA_W] = out_reg[gi];
    end
  endgenerate

  always_comb begin
    o_opcode   = out_reg[N_FIELDS-1];
    o_valid    = valid_reg;
    o_done     = (done_reg != '0);
    o_timeout  = timeout_reg;
    o_overflow = overflow_reg;
    o_index    = index_reg;
  end

endmodule

// File: tb/tb_frame_demux_n.sv
module tb_frame_demux_n;

  logic clk;
  logic reset;

  // default instance: 3 x 8, no timeout
  logic        a_rdy, a_frdy, a_valid, a_done, a_timeout, a_overflow;
  logic [7:0]  a_data, a_opcode;
  logic [23:0] a_fields;
  logic [1:0]  a_index;

  // timeout instance: 3 x 8, TIMEOUT = 4
  logic        t_rdy, t_frdy, t_valid, t_done, t_timeout, t_overflow;
  logic [7:0]  t_data, t_opcode;
  logic [23:0] t_fields;
  logic [1:0]  t_index;

  // wide instance: 5 x 16
  logic        w_rdy, w_frdy, w_valid, w_done, w_timeout, w_overflow;
  logic [15:0] w_data, w_opcode;
  logic [79:0] w_fields;
  logic [2:0]  w_index;

  int n_vec = 0;
  int n_err = 0;

  frame_demux_n u_a (
    .i_clk(clk), .reset(reset), .i_ready(a_rdy), .i_data(a_data), .i_frame_ready(a_frdy),
    .o_fields(a_fields), .o_opcode(a_opcode), .o_valid(a_valid), .o_done(a_done),
    .o_timeout(a_timeout), .o_overflow(a_overflow), .o_index(a_index)
  );

  frame_demux_n #(.TIMEOUT(4)) u_t (
    .i_clk(clk), .reset(reset), .i_ready(t_rdy), .i_data(t_data), .i_frame_ready(t_frdy),
    .o_fields(t_fields), .o_opcode(t_opcode), .o_valid(t_valid), .o_done(t_done),
    .o_timeout(t_timeout), .o_overflow(t_overflow), .o_index(t_index)
  );

  frame_demux_n #(.DATA_W(16), .N_FIELDS(5)) u_w (
    .i_clk(clk), .reset(reset), .i_ready(w_rdy), .i_data(w_data), .i_frame_ready(w_frdy),
    .o_fields(w_fields), .o_opcode(w_opcode), .o_valid(w_valid), .o_done(w_done),
    .o_timeout(w_timeout), .o_overflow(w_overflow), .o_index(w_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_word(input logic [7:0] d);
    a_rdy = 1'b1; a_data = d; tick();
  endtask

  task automatic t_word(input logic [7:0] d);
    t_rdy = 1'b1; t_data = d; tick();
  endtask

  initial begin
    reset = 1'b0;
    a_rdy = 0; a_frdy = 1; a_data = '0;
    t_rdy = 0; t_frdy = 1; t_data = '0;
    w_rdy = 0; w_frdy = 1; w_data = '0;
    tick(2);
    reset = 1'b1;

    // reset state
    chk("rst_valid",    a_valid, 0);
    chk("rst_fields",   a_fields, 0);
    chk("rst_index",    a_index, 0);
    chk("rst_done",     a_done, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_timeout",  t_timeout, 0);

    // 1: single frame, back-to-back words
    a_word(8'h11);
    chk("t1_index1", a_index, 1);
    a_word(8'h22);
    a_word(8'h33);
    chk("t1_valid", a_valid, 1);
    chk("t1_fields", a_fields, 24'h332211);
    chk("t1_opcode", a_opcode, 8'h33);
    chk("t1_done_c1", a_done, 1);
    chk("t1_index0", a_index, 0);
    a_rdy = 0; tick();
    chk("t1_done_c2", a_done, 1);
    chk("t1_consumed", a_valid, 0);
    tick();
    chk("t1_done_off", a_done, 0);

    // 2: blocked output, HOLD, overflow, release
    a_frdy = 0;
    a_word(8'h01); a_word(8'h02); a_word(8'h03);
    chk("t2_frameA", a_fields, 24'h030201);
    a_word(8'h04); a_word(8'h05); a_word(8'h06);
    chk("t2_hold_keepA", a_fields, 24'h030201);
    chk("t2_hold_noovf", a_overflow, 0);
    a_word(8'h07);
    chk("t2_overflow", a_overflow, 1);
    chk("t2_hold_index", a_index, 2);
    chk("t2_still_A", a_fields, 24'h030201);
    a_rdy = 0; a_frdy = 1; tick();
    chk("t2_frameB", a_fields, 24'h060504);
    chk("t2_valid_kept", a_valid, 1);
    chk("t2_done_restart", a_done, 1);
    chk("t2_index0", a_index, 0);
    tick();
    chk("t2_drained", a_valid, 0);
    chk("t2_ovf_sticky", a_overflow, 1);

    // 5: reset mid-frame with an unconsumed output frame
    a_frdy = 0;
    a_word(8'h31); a_word(8'h32); a_word(8'h33);
    chk("t5_loaded", a_valid, 1);
    a_word(8'h41); a_word(8'h42);
    chk("t5_partial", a_index, 2);
    a_rdy = 0; reset = 1'b0; tick();
    reset = 1'b1;
    chk("t5_valid0", a_valid, 0);
    chk("t5_fields0", a_fields, 0);
    chk("t5_index0", a_index, 0);
    chk("t5_ovf0", a_overflow, 0);
    chk("t5_done0", a_done, 0);
    a_word(8'h0A); a_word(8'h0B); a_word(8'h0C);
    chk("t5_clean", a_fields, 24'h0C0B0A);

    // 6: completion on the same edge as accept of the previous frame
    a_word(8'h21); a_word(8'h22);
    a_frdy = 1; a_word(8'h23);
    chk("t6_valid", a_valid, 1);
    chk("t6_fields", a_fields, 24'h232221);
    chk("t6_noovf", a_overflow, 0);
    chk("t6_done", a_done, 1);
    a_rdy = 0; tick();
    chk("t6_drained", a_valid, 0);

    // 3: inter-word timeout
    t_word(8'hAA);
    chk("t3_index1", t_index, 1);
    t_rdy = 0; tick(4);
    chk("t3_no_early", t_timeout, 0);
    chk("t3_index_hold", t_index, 1);
    tick();
    chk("t3_pulse", t_timeout, 1);
    chk("t3_index0", t_index, 0);
    chk("t3_out_untouched", t_valid, 0);
    tick();
    chk("t3_pulse_end", t_timeout, 0);
    t_word(8'h01); t_word(8'h02); t_word(8'h03);
    chk("t3_frame", t_fields, 24'h030201);
    // word on the expiry edge becomes field 0
    t_word(8'hBB);
    t_rdy = 0; tick(4);
    t_word(8'hCC);
    chk("t3_exp_pulse", t_timeout, 1);
    chk("t3_exp_index", t_index, 1);
    t_word(8'hDD); t_word(8'hEE);
    chk("t3_exp_frame", t_fields, 24'hEEDDCC);
    t_rdy = 0; tick();

    // 4: 5 x 16 frame
    for (int i = 1; i <= 5; i++) begin
      w_rdy = 1; w_data = 16'h1111 * i[15:0]; tick();
      if (i == 4) chk("t4_index4", w_index, 4);
    end
    w_rdy = 0;
    chk("t4_fields", w_fields, 80'h5555_4444_3333_2222_1111);
    chk("t4_opcode", w_opcode, 16'h5555);
    chk("t4_valid", w_valid, 1);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
